// File: rtl/triangle_area_cull_if.sv
// Triangle in / area out bus: vertices, tag and cull mode upstream, signed area result downstream.
// The design is the slave; the producer/consumer side is the master.
interface triangle_area_cull_if #(
    parameter int COORD_WIDTH = 17,
    parameter int TAG_WIDTH   = 8
);
    logic                                  valid_in;
    logic                                  ready_out;
    logic [2:0][1:0][COORD_WIDTH-1:0]      vertices_in;
    logic [TAG_WIDTH-1:0]                  tag_in;
    logic [1:0]                            cull_mode_in;
    logic                                  valid_out;
    logic                                  ready_in;
    logic                                  negative_out;
    logic [2*COORD_WIDTH-1:0]              area_out;
    logic [TAG_WIDTH-1:0]                  tag_out;

    modport slave (
        input  valid_in, vertices_in, tag_in, cull_mode_in, ready_in,
        output ready_out, valid_out, negative_out, area_out, tag_out
    );

    modport master (
        output valid_in, vertices_in, tag_in, cull_mode_in, ready_in,
        input  ready_out, valid_out, negative_out, area_out, tag_out
    );
endinterface

// File: rtl/triangle_area_cull.sv
// Doubled signed triangle area with facing/degenerate cull; 4 register stages, 1 triangle/cycle.
// Whole pipe stalls together when the output is held (ready_out = !valid_out | ready_in); culls leave bubbles.
module triangle_area_cull #(
    parameter int COORD_WIDTH     = 17,
    parameter int TAG_WIDTH       = 8,
    parameter int COUNT_WIDTH     = 32,
    parameter bit DROP_DEGENERATE = 1'b1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    triangle_area_cull_if.slave    bus,
    output logic [COUNT_WIDTH-1:0] culled_count_out
);
    localparam int W  = COORD_WIDTH;
    localparam int PW = 2 * W;
    localparam int SW = 2 * W + 1;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [PW-1:0] umul(input logic [W-1:0] a, input logic [W-1:0] b);
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    logic                  advance;
    logic                  p1_vld, p2_vld, p3_vld;
    logic [TAG_WIDTH-1:0]  p1_tag, p2_tag, p3_tag;
    logic [1:0]            p1_mode, p2_mode, p3_mode;
    logic [5:0][PW-1:0]    p1_prod;
    logic [2:0][SW-1:0]    p2_diff;
    logic [SW-1:0]         p3_s;

    logic                  out_vld, out_neg;
    logic [PW-1:0]         out_area;
    logic [TAG_WIDTH-1:0]  out_tag;

    logic                  s_neg, s_zero, s_pos, culled;
    logic [PW-1:0]         area_next;

    assign advance       = !out_vld || bus.ready_in;
    assign bus.ready_out = advance;

    assign bus.valid_out    = out_vld;
    assign bus.negative_out = out_neg;
    assign bus.area_out     = out_area;
    assign bus.tag_out      = out_tag;

    // |S| < 2^PW, so negating only the low PW bits yields the exact magnitude
    assign s_neg     = p3_s[SW-1];
    assign s_zero    = (p3_s == '0);
    assign s_pos     = !s_neg && !s_zero;
    assign culled    = (s_neg && p3_mode[0]) || (s_pos && p3_mode[1]) || (s_zero && DROP_DEGENERATE);
    assign area_next = s_neg ? (~p3_s[PW-1:0] + PW'(1)) : p3_s[PW-1:0];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            p1_vld <= 1'b0;
            p2_vld <= 1'b0;
            p3_vld <= 1'b0;
        end else if (advance) begin
            p1_vld <= bus.valid_in;
            p2_vld <= p1_vld;
            p3_vld <= p2_vld;
        end
    end

    always_ff @(posedge clk_in) begin
        if (advance) begin
            p1_tag     <= bus.tag_in;
            p1_mode    <= bus.cull_mode_in;
            p1_prod[0] <= umul(bus.vertices_in[1][0], bus.vertices_in[0][1]);
            p1_prod[1] <= umul(bus.vertices_in[0][0], bus.vertices_in[1][1]);
            p1_prod[2] <= umul(bus.vertices_in[2][0], bus.vertices_in[1][1]);
            p1_prod[3] <= umul(bus.vertices_in[1][0], bus.vertices_in[2][1]);
            p1_prod[4] <= umul(bus.vertices_in[0][0], bus.vertices_in[2][1]);
            p1_prod[5] <= umul(bus.vertices_in[2][0], bus.vertices_in[0][1]);

            p2_tag  <= p1_tag;
            p2_mode <= p1_mode;
            for (int k = 0; k < 3; k++) begin
                p2_diff[k] <= {1'b0, p1_prod[2*k]} - {1'b0, p1_prod[2*k+1]};
            end

            p3_tag  <= p2_tag;
            p3_mode <= p2_mode;
            p3_s    <= p2_diff[0] + p2_diff[1] + p2_diff[2];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_vld          <= 1'b0;
            out_neg          <= 1'b0;
            out_area         <= '0;
            out_tag          <= '0;
            culled_count_out <= '0;
        end else if (advance) begin
            out_vld <= p3_vld && !culled;
            if (p3_vld && !culled) begin
                out_neg  <= s_neg;
                out_area <= area_next;
                out_tag  <= p3_tag;
            end
            if (p3_vld && culled && culled_count_out != CNT_MAX) begin
                culled_count_out <= culled_count_out + COUNT_WIDTH'(1);
            end
        end
    end
endmodule
